text_banner: RTL and testbench

Parametrised, runtime-writable bitmap text overlay for the VGA demo pipeline, successor to the fixed nine-line TT08 logo overlay. It holds a ROWS×COLS one-bit glyph bitmap in registers, maps the current pixel (x, y) onto a scaled cell grid at a configurable origin, and asserts a registered `overlay_active` for lit cells. It adds per-frame horizontal scrolling with wrap-around and frame-counted blinking, and sits between the sync generator and the colour mixer.

---
 rtl/text_banner.sv | 107 ++++++++++
 tb/tb_text_banner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_banner.sv
// Runtime-writable ROWS x COLS one-bit text overlay for the VGA pipeline.
// Maps (x, y) onto a scaled cell grid and registers overlay_active; supports scrolling and blinking.
module text_banner #(
  parameter int COLS       = 22,
  parameter int ROWS       = 9,
  parameter int SCALE_LOG2 = 3,
  parameter int ORIGIN_COL = 30,
  parameter int ORIGIN_ROW = 25,
  parameter int BLINK_LOG2 = 5,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int OW        = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic            frame_start,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            scroll_en,
  input  logic            scroll_dir,
  input  logic            blink_en,
  output logic            overlay_active
);

  logic [COLS-1:0]       bitmap [ROWS];
  logic [OW-1:0]         offset;
  logic [BLINK_LOG2-1:0] frame_cnt;

  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [11:0] col;
  logic [11:0] row;
  logic        in_col;
  logic        in_row;
  logic        in_window;
  logic [OW:0] sum;
  logic [OW-1:0] src_idx;
  logic [OW-1:0] col_sel;
  logic [RW-1:0] row_sel;
  logic        lit;
  logic        blank;
  logic        wr_ok;

  // Cell coordinates keep the full 10 bits, and col/row carry a sign bit (bit 11)
  // so pixels left of / above the origin never alias into the window.
  assign cx  = x >> SCALE_LOG2;
  assign cy  = y >> SCALE_LOG2;
  assign col = {2'b00, cx} - 12'(ORIGIN_COL);
  assign row = {2'b00, cy} - 12'(ORIGIN_ROW);

  assign in_col    = !col[11] && (col[10:0] < 11'(COLS));
  assign in_row    = !row[11] && (row[10:0] < 11'(ROWS));
  assign in_window = in_col && in_row;

  // col and offset are both below COLS, so one conditional subtract finishes the modulo.
  assign sum     = {1'b0, col[OW-1:0]} + {1'b0, offset};
  assign src_idx = (sum >= (OW+1)'(COLS)) ? (sum[OW-1:0] - OW'(COLS)) : sum[OW-1:0];

  // Out-of-window indices may exceed the array bounds; steer them to a safe entry.
  assign col_sel = in_window ? src_idx : '0;
  assign row_sel = in_window ? row[RW-1:0] : '0;

  assign lit   = in_window && bitmap[row_sel][col_sel];
  assign blank = blink_en && frame_cnt[BLINK_LOG2-1];
  assign wr_ok = wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        bitmap[r] <= '0;
      end
    end else if (wr_ok) begin
      bitmap[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_start && scroll_en) begin
      if (!scroll_dir) begin
        offset <= (offset == OW'(COLS - 1)) ? '0 : offset + 1'b1;
      end else begin
        offset <= (offset == '0) ? OW'(COLS - 1) : offset - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overlay_active <= 1'b0;
    end else begin
      overlay_active <= lit && !blank;
    end
  end

endmodule

// File: tb/tb_text_banner.sv
// Self-checking bench for text_banner: directed scenarios plus randomized traffic
// compared against a cell-level reference model of the banner.
module tb_text_banner;

  localparam int COLS = 22;
  localparam int ROWS = 9;
  localparam int SCL  = 8;
  localparam int OCOL = 30;
  localparam int OROW = 25;
  localparam int BPER = 32;

  logic        clk;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_start;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [21:0] wr_data;
  logic        scroll_en;
  logic        scroll_dir;
  logic        blink_en;
  logic        overlay_active;

  int total;
  int bad;

  // reference model state
  logic [21:0] m_bmp [ROWS];
  int          m_off;
  int          m_cnt;

  text_banner dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir), .blink_en(blink_en),
    .overlay_active(overlay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_px(input int px, input int py);
    int col;
    int row;
    int s;
    col = px / SCL - OCOL;
    row = py / SCL - OROW;
    if (col < 0 || col >= COLS || row < 0 || row >= ROWS) return 1'b0;
    if (blink_en && (m_cnt % BPER) >= BPER / 2) return 1'b0;
    s = (col + m_off) % COLS;
    return m_bmp[row][s];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) m_bmp[r] = '0;
    m_off = 0;
    m_cnt = 0;
  endtask

  // One clock: predict the registered output, advance the model, then clear strobes.
  task automatic tick(output logic e);
    e = model_px(int'(x), int'(y));
    if (wr_en && int'(wr_row) < ROWS) m_bmp[wr_row] = wr_data;
    if (frame_start) begin
      m_cnt = (m_cnt + 1) % BPER;
      if (scroll_en) m_off = scroll_dir ? (m_off + COLS - 1) % COLS : (m_off + 1) % COLS;
    end
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    x = 10'd0; y = 10'd0; frame_start = 0; wr_en = 0; wr_row = 0; wr_data = 0;
    scroll_en = 0; scroll_dir = 0; blink_en = 0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic e;
    do_reset();
    total++;
    if (overlay_active !== 1'b0) begin
      bad++; $display("FAIL reset_out: got %b want 0", overlay_active);
    end
    for (int r = 0; r < ROWS; r++) begin
      x = 10'(OCOL * SCL + 8 * r); y = 10'((OROW + r) * SCL);
      tick(e);
      total++;
      if (overlay_active !== 1'b0) begin
        bad++; $display("FAIL reset_blank row %0d: got %b want 0", r, overlay_active);
      end
    end
  endtask

  task automatic test_defaults();
    logic e;
    int px [5] = '{240, 248, 280, 416, 240};
    int py [5] = '{216, 216, 216, 216, 728};
    logic want [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    wr_en = 1; wr_row = 4'd2; wr_data = 22'b0111000111000100011111;
    tick(e);
    for (int i = 0; i < 5; i++) begin
      x = 10'(px[i]); y = 10'(py[i]);
      tick(e);
      total++;
      if (overlay_active !== want[i]) begin
        bad++; $display("FAIL defaults (%0d,%0d): got %b want %b", px[i], py[i], overlay_active, want[i]);
      end
    end
  endtask

  task automatic frames(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      x = 10'd0; y = 10'd0; frame_start = 1'b1;
      tick(e);
    end
  endtask

  task automatic probe(input string name, input int px, input int py, input logic want);
    logic e;
    x = 10'(px); y = 10'(py);
    tick(e);
    total++;
    if (overlay_active !== want) begin
      bad++; $display("FAIL %s (%0d,%0d): got %b want %b", name, px, py, overlay_active, want);
    end
  endtask

  task automatic test_scroll_left();
    logic e;
    do_reset();
    wr_en = 1; wr_row = 4'd0; wr_data = 22'd1;
    tick(e);
    scroll_en = 1; scroll_dir = 0;
    frames(3);
    scroll_en = 0;
    probe("scroll_left3_col19", 392, 200, 1'b1);
    probe("scroll_left3_col0", 240, 200, 1'b0);
    frames(2);
    probe("scroll_hold", 392, 200, 1'b1);
    scroll_en = 1;
    frames(19);
    scroll_en = 0;
    probe("scroll_left22_col0", 240, 200, 1'b1);
    probe("scroll_left22_col19", 392, 200, 1'b0);
  endtask

  task automatic test_scroll_right();
    logic e;
    do_reset();
    wr_en = 1; wr_row = 4'd0; wr_data = 22'd1;
    tick(e);
    scroll_en = 1; scroll_dir = 1;
    frames(1);
    scroll_en = 0;
    probe("scroll_right_col1", 248, 200, 1'b1);
    probe("scroll_right_col0", 240, 200, 1'b0);
  endtask

  task automatic test_blink();
    logic e;
    do_reset();
    wr_en = 1; wr_row = 4'd0; wr_data = 22'd1;
    tick(e);
    blink_en = 1;
    for (int f = 0; f < 2 * BPER; f++) begin
      x = 10'd240; y = 10'd200;
      tick(e);
      total++;
      if (overlay_active !== ((f % BPER) < BPER / 2)) begin
        bad++; $display("FAIL blink frame %0d: got %b want %b", f, overlay_active, (f % BPER) < BPER / 2);
      end
      frames(1);
    end
    blink_en = 0;
    frames(20);
    probe("blink_off", 240, 200, 1'b1);
  endtask

  task automatic test_write_bounds();
    logic e;
    do_reset();
    wr_en = 1; wr_row = 4'd3; wr_data = 22'h2A5A5A;
    tick(e);
    wr_en = 1; wr_row = 4'd9; wr_data = '1;
    tick(e);
    wr_en = 1; wr_row = 4'd15; wr_data = '1;
    tick(e);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        x = 10'((OCOL + c) * SCL); y = 10'((OROW + r) * SCL + 3);
        tick(e);
        total++;
        if (overlay_active !== e) begin
          bad++; $display("FAIL wr_ignore r%0d c%0d: got %b want %b", r, c, overlay_active, e);
        end
      end
    end
    // Row 3 col 1 is lit; rewrite row 3 while that cell is being sampled.
    x = 10'd248; y = 10'd224;
    wr_en = 1; wr_row = 4'd3; wr_data = 22'h000000;
    tick(e);
    total++;
    if (overlay_active !== 1'b1) begin
      bad++; $display("FAIL wr_same_cycle_old: got %b want 1", overlay_active);
    end
    tick(e);
    total++;
    if (overlay_active !== 1'b0) begin
      bad++; $display("FAIL wr_next_cycle_new: got %b want 0", overlay_active);
    end
  endtask

  task automatic test_async_reset();
    logic e;
    do_reset();
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1; wr_row = 4'(r); wr_data = '1;
      tick(e);
    end
    scroll_en = 1; scroll_dir = 0;
    frames(5);
    scroll_en = 0;
    probe("pre_reset_lit", 256, 208, 1'b1);
    rst = 1'b1;
    #2;
    total++;
    if (overlay_active !== 1'b0) begin
      bad++; $display("FAIL async_reset_drop: got %b want 0", overlay_active);
    end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < ROWS; r++) probe("post_reset_blank", OCOL * SCL + 8 * r, (OROW + r) * SCL, 1'b0);
    wr_en = 1; wr_row = 4'd0; wr_data = 22'd1;
    tick(e);
    probe("post_reset_offset0", 240, 200, 1'b1);
  endtask

  task automatic test_random();
    logic e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        x = 10'($urandom_range(0, 1023)); y = 10'($urandom_range(0, 1023));
      end else begin
        x = 10'($urandom_range(224, 432)); y = 10'($urandom_range(192, 280));
      end
      wr_en       = ($urandom_range(0, 9) == 0);
      wr_row      = 4'($urandom_range(0, 15));
      wr_data     = 22'($urandom);
      frame_start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) scroll_en  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 63) == 0) scroll_dir = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 127) == 0) blink_en  = $urandom_range(0, 1) == 1;
      tick(e);
      total++;
      if (overlay_active !== e) begin
        bad++; $display("FAIL random #%0d (%0d,%0d): got %b want %b", i, x, y, overlay_active, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_defaults();
    test_scroll_left();
    test_scroll_right();
    test_blink();
    test_write_bounds();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
